gift_shop_repeat_sum: RTL

GIFT_SHOP_REPEAT_SUM -- requirements
Module: gift_shop_repeat_sum

---
 rtl/gift_shop_repeat_sum.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gift_shop_repeat_sum.sv
// gift_shop_repeat_sum
// Sums every ID in a stream of BCD ranges whose decimal form is an m-digit
// block repeated exactly K times. The sum is computed in closed form, one
// decimal length at a time:
//   - clamp the block to [bmin, bmax];
//   - take the arithmetic series over the blocks;
//   - scale by R = sum 10^(i*m).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, rep_k        begin a job with repetition count K (IDLE only)
//   in_valid/in_ready   range beat handshake
//   in_lo, in_hi        packed BCD bounds, most significant digit on top
//   in_last             final range of the job
//   busy, done, err     job in progress, completion pulse, sticky error
//   result              modulo-2^SUM_W sum, held until the next job ends
//   id_count            (GIFT_SHOP_ID_COUNT_EN only) number of qualifying IDs
// Optional feature macro: GIFT_SHOP_ID_COUNT_EN
module gift_shop_repeat_sum #(
  parameter int DIGITS = 10,
  parameter int SUM_W  = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            rep_k,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_lo,
  input  logic [4*DIGITS-1:0]   in_hi,
  input  logic                  in_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [SUM_W-1:0]      result
`ifdef GIFT_SHOP_ID_COUNT_EN
  ,
  output logic [SUM_W-1:0]      id_count
`endif
);
  localparam int NW = 4 * DIGITS;       // packed BCD width
  localparam int BW = NW + 4;           // binary width; 10^DIGITS < 2^NW
  localparam int PW = SUM_W + NW + 8;   // exact series/product width
  localparam int LW = 5;                // holds lengths 1..16

  typedef enum logic [3:0] {IDLE, ACCEPT, LEN, SPLIT, CLAMP, SERIES, SCALE, ACCUM, DONE} state_t;
  state_t state;

  logic [3:0]       k;
  logic [NW-1:0]    lo, hi;
  logic             last;
  logic [LW-1:0]    len, len_lo, len_hi;
  logic [BW-1:0]    rf, elo_b, ehi_b, bmin, bmax;
  logic [PW-1:0]    s;
  logic [SUM_W-1:0] acc, contrib;
`ifdef GIFT_SHOP_ID_COUNT_EN
  logic [SUM_W-1:0] cnt, cnt_acc;
`endif

  function automatic logic [BW-1:0] bcd2bin(input logic [NW-1:0] v);
    logic [BW-1:0] x;
    x = '0;
    for (int i = DIGITS - 1; i >= 0; i--) x = (x << 3) + (x << 1) + BW'(v[4*i +: 4]);
    return x;
  endfunction

  function automatic logic [LW-1:0] bcd_len(input logic [NW-1:0] v);
    logic [LW-1:0] n;
    n = LW'(1);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] != 4'd0) n = LW'(i + 1);
    return n;
  endfunction

  function automatic logic bcd_bad(input logic [NW-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic logic [BW-1:0] pow10(input logic [LW-1:0] n);
    logic [BW-1:0] p;
    p = BW'(1);
    for (int i = 0; i < DIGITS; i++) if (LW'(i) < n) p = (p << 3) + (p << 1);
    return p;
  endfunction

  // R = 1 + 10^m + 10^(2m) + ... (K terms): turns a block into its repetition
  function automatic logic [BW-1:0] rep_factor(input logic [LW-1:0] m, input logic [3:0] kk);
    logic [BW-1:0] p, r;
    p = pow10(m);
    r = '0;
    for (int i = 0; i < DIGITS; i++) if (i < int'(kk)) r = r * p + BW'(1);
    return r;
  endfunction

  function automatic logic [NW-1:0] nines(input logic [LW-1:0] n);
    logic [NW-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) if (LW'(i) < n) v[4*i +: 4] = 4'd9;
    return v;
  endfunction

  function automatic logic [NW-1:0] one_at(input logic [LW-1:0] n);
    logic [NW-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) if (LW'(i) == n - LW'(1)) v[4*i +: 4] = 4'd1;
    return v;
  endfunction

  logic [LW-1:0] k5, m_c, len_rem;
  logic [NW-1:0] elo_bcd, ehi_bcd, top_lo, top_hi;
  logic [PW-1:0] a_sum, b_cnt;
  logic          nonempty;
  int            sh;

  always_comb begin
    k5       = {1'b0, k};
    m_c      = len / k5;
    len_rem  = len % k5;
    // Lengths strictly between the bounds' own lengths span the full decade
    elo_bcd  = (len == len_lo) ? lo : one_at(len);
    ehi_bcd  = (len == len_hi) ? hi : nines(len);
    sh       = 4 * (int'(len) - int'(m_c));
    top_lo   = elo_bcd >> sh;
    top_hi   = ehi_bcd >> sh;
    a_sum    = PW'(bmin) + PW'(bmax);
    b_cnt    = PW'(bmax) - PW'(bmin) + PW'(1);
    nonempty = (bmax >= bmin);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      acc      <= '0;
`ifdef GIFT_SHOP_ID_COUNT_EN
      id_count <= '0;
      cnt_acc  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          k    <= rep_k;
          acc  <= '0;
          err  <= 1'b0;
          busy <= 1'b1;
`ifdef GIFT_SHOP_ID_COUNT_EN
          cnt_acc <= '0;
`endif
          if (rep_k < 4'd2 || {1'b0, rep_k} > LW'(DIGITS)) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= ACCEPT;
          end
        end
        ACCEPT: if (in_valid) begin
          lo       <= in_lo;
          hi       <= in_hi;
          last     <= in_last;
          in_ready <= 1'b0;
          state    <= LEN;
        end
        LEN: begin
          if (bcd_bad(lo) || bcd_bad(hi) || lo > hi) begin
            // Packed BCD compares like the numbers it encodes once digits are legal
            if (bcd_bad(lo) || bcd_bad(hi)) err <= 1'b1;
            if (last) state <= DONE;
            else begin
              in_ready <= 1'b1;
              state    <= ACCEPT;
            end
          end else begin
            len_lo <= bcd_len(lo);
            len_hi <= bcd_len(hi);
            len    <= bcd_len(lo);
            state  <= SPLIT;
          end
        end
        SPLIT: begin
          if (len_rem != '0) begin
            if (len == len_hi) begin
              if (last) state <= DONE;
              else begin
                in_ready <= 1'b1;
                state    <= ACCEPT;
              end
            end else begin
              len <= len + LW'(1);
            end
          end else begin
            rf    <= rep_factor(m_c, k);
            elo_b <= bcd2bin(elo_bcd);
            ehi_b <= bcd2bin(ehi_bcd);
            bmin  <= bcd2bin(top_lo);
            bmax  <= bcd2bin(top_hi);
            state <= CLAMP;
          end
        end
        CLAMP: begin
          if (bmin * rf < elo_b) bmin <= bmin + BW'(1);
          if (bmax * rf > ehi_b) bmax <= bmax - BW'(1);
          state <= SERIES;
        end
        SERIES: begin
          // Halve the even factor so the series sum stays exact
          if (nonempty) s <= a_sum[0] ? a_sum * (b_cnt >> 1) : (a_sum >> 1) * b_cnt;
          else s <= '0;
`ifdef GIFT_SHOP_ID_COUNT_EN
          cnt <= nonempty ? SUM_W'(b_cnt) : '0;
`endif
          state <= SCALE;
        end
        SCALE: begin
          contrib <= SUM_W'(s * PW'(rf));
          state   <= ACCUM;
        end
        ACCUM: begin
          acc <= acc + contrib;
`ifdef GIFT_SHOP_ID_COUNT_EN
          cnt_acc <= cnt_acc + cnt;
`endif
          if (len == len_hi) begin
            if (last) state <= DONE;
            else begin
              in_ready <= 1'b1;
              state    <= ACCEPT;
            end
          end else begin
            len   <= len + LW'(1);
            state <= SPLIT;
          end
        end
        DONE: begin
          result <= acc;
`ifdef GIFT_SHOP_ID_COUNT_EN
          id_count <= cnt_acc;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
